// File: rtl/ram_stream_loader.sv
// Boot loader: parses a framed byte stream and writes little-endian words
// into one of NUM_RAMS on-chip RAMs through a shared registered write port.
module ram_stream_loader #(
  parameter int         DATA_WIDTH = 32,
  parameter int         ADDR_WIDTH = 12,
  parameter int         NUM_RAMS   = 2,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic [NUM_RAMS-1:0]   ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  core_hold,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int                 BPW        = DATA_WIDTH / 8;
  localparam logic [3:0]         LAST_BYTE  = 4'(BPW - 1);
  localparam logic [NUM_RAMS-1:0] WE_ONE    = NUM_RAMS'(1);
  localparam logic [4:0]         NUM_RAMS_W = 5'(NUM_RAMS);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_ADDR0,
    S_ADDR1,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_ERROR
  } state_t;

  state_t                state;
  logic [3:0]            target;
  logic [7:0]            addr_lo;
  logic [7:0]            len_lo;
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0]           words_left;
  logic [3:0]            byte_idx;
  logic [DATA_WIDTH-1:0] word_buf;
  logic [7:0]            csum;

  logic                  accept;
  logic [15:0]           addr_full;
  logic [15:0]           len_full;
  logic [DATA_WIDTH-1:0] word_next;

  assign accept    = in_valid & in_ready;
  assign addr_full = {in_data, addr_lo};
  assign len_full  = {in_data, len_lo};

  // Partial word with the incoming byte merged into its little-endian lane.
  always_comb begin
    word_next                   = word_buf;
    word_next[8*byte_idx +: 8]  = in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      target     <= '0;
      addr_lo    <= '0;
      len_lo     <= '0;
      addr       <= '0;
      words_left <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
      csum       <= '0;
      in_ready   <= 1'b0;
      ram_we     <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      core_hold  <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      ram_we     <= '0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      if (state == S_ERROR) begin
        state    <= S_IDLE;
        in_ready <= 1'b1;
      end else begin
        in_ready <= 1'b1;
        if (accept) begin
          case (state)
            S_IDLE: begin
              if (in_data == SYNC_BYTE) begin
                state     <= S_CMD;
                core_hold <= 1'b1;
                csum      <= '0;
                byte_idx  <= '0;
              end
            end
            S_CMD: begin
              csum   <= csum ^ in_data;
              target <= in_data[3:0];
              if ({1'b0, in_data[3:0]} >= NUM_RAMS_W) begin
                state      <= S_ERROR;
                in_ready   <= 1'b0;
                load_error <= 1'b1;
                core_hold  <= 1'b0;
              end else begin
                state <= S_ADDR0;
              end
            end
            S_ADDR0: begin
              csum    <= csum ^ in_data;
              addr_lo <= in_data;
              state   <= S_ADDR1;
            end
            S_ADDR1: begin
              csum  <= csum ^ in_data;
              addr  <= addr_full[ADDR_WIDTH-1:0];
              state <= S_LEN0;
            end
            S_LEN0: begin
              csum   <= csum ^ in_data;
              len_lo <= in_data;
              state  <= S_LEN1;
            end
            S_LEN1: begin
              csum       <= csum ^ in_data;
              words_left <= len_full;
              state      <= (len_full == 16'd0) ? S_CSUM : S_DATA;
            end
            S_DATA: begin
              csum     <= csum ^ in_data;
              word_buf <= word_next;
              // Last lane of a word: issue the write and step the address.
              if (byte_idx == LAST_BYTE) begin
                byte_idx   <= '0;
                ram_we     <= WE_ONE << target;
                ram_addr   <= addr;
                ram_wdata  <= word_next;
                addr       <= addr + ADDR_WIDTH'(1);
                words_left <= words_left - 16'd1;
                if (words_left == 16'd1)
                  state <= S_CSUM;
              end else begin
                byte_idx <= byte_idx + 4'd1;
              end
            end
            S_CSUM: begin
              core_hold <= 1'b0;
              if (in_data == csum) begin
                load_done <= 1'b1;
                state     <= S_IDLE;
              end else begin
                load_error <= 1'b1;
                in_ready   <= 1'b0;
                state      <= S_ERROR;
              end
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_stream_loader.sv
// Directed + randomized bench for ram_stream_loader: frames are built from
// their field values and the expected writes/pulses come from that description.
module tb_ram_stream_loader;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int NR = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic [NR-1:0] ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          core_hold;
  logic          load_done;
  logic          load_error;

  always #5 clk = ~clk;

  ram_stream_loader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_RAMS  (NR),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .core_hold (core_hold),
    .load_done (load_done),
    .load_error(load_error)
  );

  typedef struct {
    int          ram;
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         obs_q[$];
  logic [7:0]  tx_q[$];
  int          acc_q[$];
  logic [31:0] fixed_words[$];
  int          sync_idx;

  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  int   done_cnt, err_cnt, done_cyc, err_cyc;
  int   hold_cnt, hold_first, rdy_low_cnt;
  logic pulse_hold;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the DUT mid-cycle: log writes, pulses, hold and ready activity.
  always @(negedge clk) begin
    if (reset) begin
      for (int r = 0; r < NR; r++)
        if (ram_we[r]) obs_q.push_back('{r, int'(ram_addr), ram_wdata, cyc});
      if (load_done) begin
        done_cnt++;
        done_cyc   = cyc;
        pulse_hold = core_hold;
      end
      if (load_error) begin
        err_cnt++;
        err_cyc    = cyc;
        pulse_hold = core_hold;
      end
      if (core_hold) begin
        if (hold_cnt == 0) hold_first = cyc;
        hold_cnt++;
      end
      if (!in_ready) rdy_low_cnt++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one byte, optionally after random idle cycles, and note its accept edge.
  task automatic applyStimulus(input logic [7:0] b, input bit gaps);
    int tries;
    int n;
    tries = 0;
    if (gaps) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
    end
    do begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      tries++;
    end while (in_ready !== 1'b1 && tries < 16);
    checkOutput("byte accepted", 64'(in_ready), 64'(1));
    acc_q.push_back(cyc + 1);
  endtask

  task automatic build_frame(input logic [7:0] cmd, input logic [15:0] a, input int nw,
                             input bit bad, input int n_garbage);
    logic [7:0]  cs;
    logic [7:0]  g;
    logic [31:0] w;
    logic [15:0] len;
    int          tgt;
    tx_q.delete();
    exp_q.delete();
    for (int i = 0; i < n_garbage; i++) begin
      g = 8'($urandom);
      if (g == 8'hA5) g = 8'h5A;
      tx_q.push_back(g);
    end
    sync_idx = tx_q.size();
    tx_q.push_back(8'hA5);
    tx_q.push_back(cmd);
    tgt = int'(cmd[3:0]);
    if (tgt >= NR) begin
      fixed_words.delete();
      return;
    end
    len = 16'(nw);
    tx_q.push_back(a[7:0]);
    tx_q.push_back(a[15:8]);
    tx_q.push_back(len[7:0]);
    tx_q.push_back(len[15:8]);
    cs = cmd ^ a[7:0] ^ a[15:8] ^ len[7:0] ^ len[15:8];
    for (int k = 0; k < nw; k++) begin
      w = (fixed_words.size() != 0) ? fixed_words.pop_front() : $urandom;
      for (int j = 0; j < 4; j++) begin
        tx_q.push_back(w[8*j +: 8]);
        cs = cs ^ w[8*j +: 8];
      end
      exp_q.push_back('{tgt, (int'(a) + k) % (1 << AW), w, 0});
    end
    tx_q.push_back(bad ? ~cs : cs);
  endtask

  task automatic run_frame(input bit gaps, input bit exp_err, input string name);
    int last;
    #1;
    obs_q.delete();
    acc_q.delete();
    done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -1;
    hold_cnt = 0; hold_first = -1; rdy_low_cnt = 0; pulse_hold = 1'b1;
    foreach (tx_q[i]) applyStimulus(tx_q[i], gaps);
    repeat (6) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    last = acc_q[acc_q.size()-1];
    checkOutput({name, " write count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checkOutput({name, " write ram"},  64'(obs_q[k].ram),  64'(exp_q[k].ram));
      checkOutput({name, " write addr"}, 64'(obs_q[k].addr), 64'(exp_q[k].addr));
      checkOutput({name, " write data"}, 64'(obs_q[k].data), 64'(exp_q[k].data));
      checkOutput({name, " write cycle"}, 64'(obs_q[k].cyc), 64'(acc_q[sync_idx + 6 + 4*k + 3]));
    end
    checkOutput({name, " done count"},  64'(done_cnt), 64'(exp_err ? 0 : 1));
    checkOutput({name, " error count"}, 64'(err_cnt),  64'(exp_err ? 1 : 0));
    if (exp_err) checkOutput({name, " error cycle"}, 64'(err_cyc), 64'(last));
    else         checkOutput({name, " done cycle"},  64'(done_cyc), 64'(last));
    checkOutput({name, " hold at pulse"}, 64'(pulse_hold), 64'(0));
    checkOutput({name, " hold start"},  64'(hold_first), 64'(acc_q[sync_idx]));
    checkOutput({name, " hold length"}, 64'(hold_cnt), 64'(last - acc_q[sync_idx]));
    checkOutput({name, " ready low cycles"}, 64'(rdy_low_cnt), 64'(exp_err ? 1 : 0));
  endtask

  initial begin
    logic [7:0]  cmd;
    logic [15:0] a;
    int          nw;
    bit          bad;

    #22;
    checkOutput("reset outputs",
                64'({in_ready, ram_we, ram_addr, ram_wdata, core_hold, load_done, load_error}), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("ready after reset", 64'(in_ready), 64'(1));

    fixed_words = '{32'h12345678, 32'hDEADBEEF};
    build_frame(8'h00, 16'h0010, 2, 1'b0, 0);
    run_frame(1'b0, 1'b0, "basic");

    fixed_words = '{32'h12345678, 32'hDEADBEEF};
    build_frame(8'h00, 16'h0010, 2, 1'b1, 0);
    run_frame(1'b0, 1'b1, "bad csum");

    build_frame(8'h02, 16'h0000, 0, 1'b0, 0);
    run_frame(1'b0, 1'b1, "bad cmd");

    fixed_words = '{32'hA5A5A5A5};
    build_frame(8'hF1, 16'h0123, 3, 1'b0, 0);
    run_frame(1'b0, 1'b0, "ram1 sync data");

    build_frame(8'h00, 16'h0FFF, 2, 1'b0, 0);
    run_frame(1'b0, 1'b0, "addr wrap");

    build_frame(8'h01, 16'hF005, 1, 1'b0, 0);
    run_frame(1'b0, 1'b0, "high addr bits");

    build_frame(8'h01, 16'h0000, 0, 1'b0, 0);
    run_frame(1'b0, 1'b0, "zero length");

    fixed_words = '{32'h12345678, 32'hDEADBEEF};
    build_frame(8'h00, 16'h0010, 2, 1'b0, 0);
    run_frame(1'b1, 1'b0, "basic with gaps");

    for (int f = 0; f < 4; f++) begin
      cmd = {4'($urandom), 4'($urandom_range(0, 1))};
      a   = 16'($urandom);
      nw  = $urandom_range(0, 4);
      bad = ($urandom_range(0, 3) == 0);
      build_frame(cmd, a, nw, bad, $urandom_range(0, 3));
      run_frame(1'b1, bad, "random");
    end

    // Abort a frame with reset after three data bytes.
    build_frame(8'h00, 16'h0100, 2, 1'b0, 0);
    #1;
    obs_q.delete();
    for (int i = 0; i < 9; i++) applyStimulus(tx_q[i], 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("hold before reset", 64'(core_hold), 64'(1));
    #2 reset = 1'b0;
    #1;
    checkOutput("async reset outputs",
                64'({in_ready, ram_we, ram_addr, ram_wdata, core_hold, load_done, load_error}), 64'(0));
    checkOutput("no partial writes", 64'(obs_q.size()), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    build_frame(8'h01, 16'h0200, 2, 1'b0, 5);
    run_frame(1'b1, 1'b0, "after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
